// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial front end for the 1101 string detector.
// Takes WIDTH-bit words over a valid/ready handshake and emits one bit per
// clock on a registered serial line. A word accepted while the previous
// word's last bit is on the line follows it with no bubble, so bit patterns
// that straddle a word boundary stay contiguous for the detector.
//
// Handshake: a word transfers on a rising clock edge where load_valid and
// load_ready are both high. load_ready depends only on registered state
// (FSM state and bit counter), never on load_valid, so upstream may hold
// load_valid high for as long as it likes; data_in is sampled only on the
// transferring edge and ignored at all other times.
module seq_serializer #(
    parameter int WIDTH     = 8,  // word length, 2..32
    parameter int MSB_FIRST = 1   // 1: bit WIDTH-1 goes out first; 0: bit 0 first
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             dbg_state   // 0 = IDLE, 1 = SHIFT
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    // Holds the bits of the current word that have not yet reached ser_out;
    // the bit on the line lives in ser_out_q.
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ser_out_q, ser_out_d;
    logic               ser_valid_q, ser_valid_d;
    logic               word_done_q, word_done_d;

    logic               last_bit;
    logic               accept;

    // Bit that leaves the word first in the configured order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0) begin
            return w[WIDTH-1];
        end
        return w[0];
    endfunction

    // Word with its head bit removed, next bit moved into the head position.
    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0) begin
            return {w[WIDTH-2:0], 1'b0};
        end
        return {1'b0, w[WIDTH-1:1]};
    endfunction

    // State and output registers; reset lands in IDLE with a quiet line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
        end
    end

    // Ready only in IDLE or while the last bit of a word is on the line.
    always_comb begin
        last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
        load_ready = (state_q == IDLE) || last_bit;
        accept     = load_valid && load_ready;
    end

    // Next-state logic: load, advance one bit, or fall back to IDLE.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        word_done_d = 1'b0;

        if (accept) begin
            // New word: first bit goes straight onto the line, the rest is
            // kept in the shift register. Covers both IDLE and the last-bit
            // edge of a running word, which is what makes the stream gapless.
            state_d     = SHIFT;
            ser_out_d   = head_bit(data_in);
            sreg_d      = drop_head(data_in);
            cnt_d       = '0;
            ser_valid_d = 1'b1;
            word_done_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ser_out_d   = 1'b0;
                    ser_valid_d = 1'b0;
                end
                SHIFT: begin
                    if (last_bit) begin
                        // Word finished with nothing queued behind it.
                        state_d     = IDLE;
                        sreg_d      = '0;
                        cnt_d       = '0;
                        ser_out_d   = 1'b0;
                        ser_valid_d = 1'b0;
                    end else begin
                        ser_out_d   = head_bit(sreg_q);
                        sreg_d      = drop_head(sreg_q);
                        cnt_d       = cnt_q + CNT_W'(1);
                        ser_valid_d = 1'b1;
                        // Flag the cycle in which the final bit sits on the line.
                        word_done_d = ((cnt_q + CNT_W'(1)) == LAST_CNT);
                    end
                end
                default: begin
                    state_d     = IDLE;
                    ser_out_d   = 1'b0;
                    ser_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Registered outputs and state visibility.
    always_comb begin
        ser_out   = ser_out_q;
        ser_valid = ser_valid_q;
        word_done = word_done_q;
        dbg_state = state_q;
    end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the string-recognition datapath. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a registered serial line that drives the serial input of the 1101 pattern detector. Supports back-to-back words with no bubble, so patterns spanning a word boundary stay contiguous. Also reports per-word completion.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset; forces IDLE immediately.
- data_in  input  WIDTH  word to serialize; sampled only on an accepted load.
- load_valid  input  1  upstream has a word on data_in.
- load_ready  output  1  block can accept a word this cycle; combinational from state and bit counter only, never from load_valid.
- ser_out  output  1  registered serial bit; connects to the detector's serial input.
- ser_valid  output  1  registered; high while ser_out carries a data bit.
- word_done  output  1  registered; high for the cycle in which the last bit of a word is on ser_out.

## Operation
- Load accepted on a rising edge where load_valid && load_ready.
- States:
  - IDLE: ser_valid=0, ser_out=0, load_ready=1. Accepted load captures data_in into the shift register, bit_cnt=0, goes to SHIFT.
  - SHIFT: ser_out = current head bit, ser_valid=1. Each edge advances the head by one bit and increments bit_cnt.
- load_ready in SHIFT is 1 only when bit_cnt==WIDTH-1, i.e. the last bit is on the line.
- At the last-bit edge:
  - Load accepted: capture the new word, bit_cnt=0, stay in SHIFT. The new word's first bit follows the old last bit on the next cycle with no gap.
  - No load: return to IDLE.
- bit_cnt width is clog2(WIDTH); it never exceeds WIDTH-1 and is not free-running.
- Bit order:
  - MSB_FIRST=1: bits WIDTH-1 down to 0.
  - MSB_FIRST=0: bits 0 up to WIDTH-1.
- data_in changes while not accepted have no effect; the captured word is immune to later data_in changes.
- Idle gaps drive ser_out=0. Downstream therefore sees zeros between non-contiguous words. This is the defined behaviour, not an error.
- reset asserted at any time, including mid-word:
  - State goes to IDLE, shift register and bit_cnt clear, ser_out=0, ser_valid=0, word_done=0, asynchronously.
  - The partial word is discarded.
  - load_valid is ignored while reset is high.
- Reset values: ser_out=0, ser_valid=0, word_done=0, load_ready=1 (IDLE).

## Timing
- Latency: load accepted at edge k puts the first bit on ser_out after edge k. That bit is valid for the whole cycle k..k+1.
- Last bit of the word is present after edge k+WIDTH-1. word_done is high in that same cycle.
- Throughput: one bit per clock; a continuous stream of loads yields ser_valid held high indefinitely.
- Word accepted at the last-bit edge: the next first bit appears after that edge, giving zero bubble cycles.
- Returning to IDLE drops ser_valid and word_done after the edge following the last bit.
- All outputs except load_ready are flop outputs; load_ready settles within the cycle from registered state.

## Test plan
- Reset: hold reset 3 cycles with load_valid=1 and data_in=8'hFF -> ser_out=0, ser_valid=0, word_done=0, load_ready=1 throughout; no load captured.
- Single word, MSB_FIRST=1, data_in=8'hD0 loaded once:
  - ser_out reads 1,1,0,1,0,0,0,0 over 8 cycles with ser_valid=1.
  - word_done is high only on the 8th bit.
  - Then IDLE with ser_out=0.
  - Attached detector output rises one cycle after the 4th bit.
- Back-to-back: load 8'h01 then 8'hA0, second load presented with load_valid held high:
  - Second word accepted exactly at the first word's last-bit edge.
  - ser_valid stays high for 16 consecutive cycles.
  - Stream is 0000000110100000; the 1101 spanning the boundary is detected.
- load_ready gating: load_valid held high with changing data_in mid-word -> load_ready=0 for bits 0..6; no capture until bit 7; serialized word equals the value sampled at the accept edge.
- Reset mid-word: assert reset while bit 3 of 8'hFF is on the line -> ser_out and ser_valid drop to 0 immediately. After release, the next load of 8'h0F serializes cleanly as 00001111.
- LSB-first: WIDTH=4, MSB_FIRST=0, data_in=4'b1011 -> ser_out reads 1,1,0,1; word_done on the 4th bit.
